soc_csr_bank: RTL and testbench
===============================

// Module: soc_csr_bank
// PURPOSE
//  Parametrised CSR slave on the SoC word bus: NUM_RW control regs, NUM_RO hw status regs,
//  an IRQ pending (W1C) / mask pair and a registered IRQ output.
//  Adds configurable read latency with a rdy handshake and per-register write strobes.
//  Sits between the SoC interconnect and a peripheral core.
// PARAMETERS
//  NUM_RW   8    number of 32b RW control registers (1..64)
//  NUM_RO   4    number of 32b RO status registers (0..64)
//  IRQ_W    8    number of IRQ pending/mask bits (1..32)
//  ADDR_W   11   word-address width; required: NUM_RW+NUM_RO+3 <= 2**ADDR_W
//  RD_LAT   1    read latency in cycles, vld accept to rdy (1..4)
//  RW_RST   '0   [NUM_RW*32-1:0] reset values of the control regs, reg i at [32i+:32]
// PORTS
//  clk        in   1            bus clock, single domain
//  arst_n     in   1            asynchronous active-low reset
//  vld        in   1            request valid; held by master until rdy
//  rdy        out  1            request complete (write: same cycle; read: rdat valid)
//  we         in   4            byte write enables; |we=write, we==0 read
//  addr       in   ADDR_W       word address
//  wdat       in   32           write data
//  rdat       out  32           read data, valid when rdy & read
//  ctrl_o     out  NUM_RW*32    control register contents
//  wr_stb_o   out  NUM_RW       1-cycle pulse, cycle after any write to reg i
//  status_i   in   NUM_RO*32    status inputs, sampled at read accept
//  irq_set_i  in   IRQ_W        per-bit set pulses into pending
//  irq_o      out  1            registered |(pend & mask)
// BEHAVIOUR
//  Map (word idx): 0..NUM_RW-1 ctrl; NUM_RW..+NUM_RO-1 status; P=NUM_RW+NUM_RO pend; P+1 mask.
//  Reset (async, arst_n=0): ctrl=RW_RST, pend=0, mask=0, rdy=0, rdat=0, wr_stb_o=0,
//   irq_o=0, FSM=IDLE; in-flight read is dropped, no rdy issued for it.
//  Write: in IDLE, vld&|we -> rdy=1 combinationally same cycle; byte lanes per we[k] update.
//   Ctrl: write registered at clock edge; wr_stb_o[i]=1 next cycle, even if we bytes unchanged data.
//   Pend: W1C per byte lane; mask: RW. Status/unmapped writes: ignored, still rdy=1.
//  Read FSM: IDLE -> (vld & we==0) capture data at accept edge T -> WAIT (RD_LAT-1 cycles)
//   -> DONE: rdy=1, rdat valid for exactly one cycle at T+RD_LAT -> IDLE.
//   RD_LAT=1: accept in cycle T, rdy in T+1. vld during WAIT/DONE not re-accepted.
//   Master drops or changes vld after rdy; a new vld in the cycle after DONE is accepted.
//  rdat holds last read value outside rdy; unmapped reads return 32'h0.
//  IRQ: pend[b] <= (pend[b] & ~clr[b]) | irq_set_i[b]; set beats W1C clear in same cycle.
//   irq_o registered: 1 cycle after pend&mask becomes non-zero; bits >= IRQ_W read 0.
//  Width rules: addr compared in full ADDR_W; no aliasing above map top.
// CONFIGURATION
//  CSR_BANK_ERRCNT_EN defined: reg idx P+2 = 16b saturating count of accesses to unmapped
//   addresses (read or write) in [15:0], [31:16]=0; any write to P+2 clears to 0
//   (clear beats increment); resets to 0; stays 16'hFFFF at saturation.
//  Not defined: idx P+2 is unmapped (reads 0, writes ignored), no counter logic.
// TESTING
//  1 Reset RW_RST[31:0]=32'hA5A5_0001: read idx0 -> rdat=32'hA5A5_0001, rdy at T+RD_LAT.
//  2 Write idx1 wdat=32'h1234_5678 we=4'b0011 -> ctrl reg1=32'h0000_5678,
//    wr_stb_o[1] pulse next cycle, rdy same cycle as vld.
//  3 RD_LAT=3, status_i reg0=32'hCAFE_F00D: read idx NUM_RW -> rdy exactly 3 cycles after accept;
//    rdy high for 1 cycle only.
//  4 mask=1, irq_set_i[0] pulse -> irq_o=1 next cycle; W1C 1 to pend with
//    simultaneous irq_set_i[0] -> pend[0] stays 1.
//  5 Assert arst_n=0 during read WAIT -> rdy never asserts for it; after release,
//    outputs at reset values, next read completes normally.
//  6 ERRCNT_EN: 3 accesses to idx 2**ADDR_W-1 -> read P+2 = 3; write P+2 -> reads 0.

Source files
------------

// File: rtl/soc_csr_bank.sv
// -----------------------------------------------------------------------------
// soc_csr_bank
//   CSR slave on the SoC word bus. It sits between the interconnect and a
//   peripheral core and provides:
//   - NUM_RW 32-bit control registers, with byte-lane writes and a one-cycle
//     write strobe per register.
//   - NUM_RO 32-bit read-only status registers, sampled from the core.
//   - An IRQ pending register (write 1 to clear) and a mask register, which
//     drive a registered interrupt output.
//   Writes complete in the cycle they are presented. Reads complete RD_LAT
//   cycles after they are accepted.
//
//   Word map:
//     0 .. NUM_RW-1                    ctrl
//     NUM_RW .. NUM_RW+NUM_RO-1        status
//     P = NUM_RW+NUM_RO                irq pending (W1C)
//     P+1                              irq mask
//     P+2                              unmapped error counter, present only
//                                      when CSR_BANK_ERRCNT_EN is defined
//
// Optional feature macro: CSR_BANK_ERRCNT_EN
//   When defined, word P+2 holds a 16-bit saturating count of accesses to
//   unmapped addresses. Any write to P+2 clears the count. When the macro is
//   not defined, P+2 is unmapped.
//
// Ports
//   clk        in   1            bus clock
//   arst_n     in   1            asynchronous active-low reset
//   vld        in   1            request valid; the master holds it until rdy
//   rdy        out  1            request complete (write: same cycle; read: rdat valid)
//   we         in   4            byte write enables; any bit set = write, 0 = read
//   addr       in   ADDR_W       word address
//   wdat       in   32           write data
//   rdat       out  32           read data; holds the last read value
//   ctrl_o     out  NUM_RW*32    control register contents
//   wr_stb_o   out  NUM_RW       one-cycle pulse in the cycle after a write to reg i
//   status_i   in   NUM_RO*32    status inputs, sampled when a read is accepted
//   irq_set_i  in   IRQ_W        per-bit set pulses into pending
//   irq_o      out  1            registered |(pend & mask)
// -----------------------------------------------------------------------------
module soc_csr_bank #(
    parameter int                   NUM_RW = 8,
    parameter int                   NUM_RO = 4,
    parameter int                   IRQ_W  = 8,
    parameter int                   ADDR_W = 11,
    parameter int                   RD_LAT = 1,
    parameter logic [NUM_RW*32-1:0] RW_RST = '0
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   vld,
    output logic                   rdy,
    input  logic [3:0]             we,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [31:0]            wdat,
    output logic [31:0]            rdat,
    output logic [NUM_RW*32-1:0]   ctrl_o,
    output logic [NUM_RW-1:0]      wr_stb_o,
    input  logic [NUM_RO*32-1:0]   status_i,
    input  logic [IRQ_W-1:0]       irq_set_i,
    output logic                   irq_o
);

    localparam logic [31:0] IDX_PEND = 32'(NUM_RW + NUM_RO);
    localparam logic [31:0] IDX_MASK = IDX_PEND + 32'd1;
    localparam logic [31:0] IDX_ERR  = IDX_PEND + 32'd2;
    // WAIT is held for RD_LAT-1 cycles, so the counter starts at RD_LAT-2.
    localparam logic [1:0]  WAIT_INIT = 2'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state;
    logic [1:0]         wait_cnt;
    logic [31:0]        addr_w;
    logic [31:0]        lane_mask;
    logic [31:0]        rd_mux;
    logic [31:0]        rd_buf;
    logic [31:0]        rdat_q;
    logic [31:0]        ctrl_q [NUM_RW];
    logic [NUM_RW-1:0]  stb_q;
    logic [IRQ_W-1:0]   pend_q;
    logic [IRQ_W-1:0]   mask_q;
    logic [IRQ_W-1:0]   mask_d;
    logic [IRQ_W-1:0]   clr;
    logic               irq_q;
    logic               wr_acc;
    logic               rd_acc;
    logic               unmapped;

    // Compare the address at its full width so that nothing above the top of
    // the map aliases onto a register.
    assign addr_w    = 32'(addr);
    assign lane_mask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};

    // Requests are accepted only in IDLE. vld stays high through WAIT/DONE,
    // but the read is not accepted a second time.
    assign wr_acc = (state == S_IDLE) && vld && (we != 4'b0000);
    assign rd_acc = (state == S_IDLE) && vld && (we == 4'b0000);

    // A write completes combinationally in its accept cycle. A read completes
    // from the registered DONE state.
    assign rdy = wr_acc || (state == S_DONE);

`ifdef CSR_BANK_ERRCNT_EN
    assign unmapped = (addr_w > IDX_ERR);
`else
    assign unmapped = (addr_w >= IDX_ERR);
`endif

`ifdef CSR_BANK_ERRCNT_EN
    logic [15:0] err_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            err_q <= 16'h0000;
        end else if (wr_acc && (addr_w == IDX_ERR)) begin
            // Clear takes priority. A write to P+2 is mapped, so it cannot
            // also count as an unmapped access.
            err_q <= 16'h0000;
        end else if ((wr_acc || rd_acc) && unmapped && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'd1;
        end
    end
`endif

    // Read mux: the value presented at the accept edge.
    always_comb begin
        // NOTE: assign a default first so that every path drives rd_mux and no latch is inferred.
        rd_mux = 32'h0000_0000;
        for (int i = 0; i < NUM_RW; i++) begin
            if (addr_w == 32'(i)) rd_mux = ctrl_q[i];
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (addr_w == 32'(NUM_RW + j)) rd_mux = status_i[32*j +: 32];
        end
        if (addr_w == IDX_PEND) rd_mux = 32'(pend_q);
        if (addr_w == IDX_MASK) rd_mux = 32'(mask_q);
`ifdef CSR_BANK_ERRCNT_EN
        if (addr_w == IDX_ERR)  rd_mux = {16'h0000, err_q};
`endif
    end

    // Per-bit W1C clear of pending and byte-lane update of the mask.
    always_comb begin
        clr    = '0;
        mask_d = mask_q;
        for (int b = 0; b < IRQ_W; b++) begin
            if (wr_acc && (addr_w == IDX_PEND)) clr[b] = lane_mask[b] & wdat[b];
            if (wr_acc && (addr_w == IDX_MASK) && lane_mask[b]) mask_d[b] = wdat[b];
        end
    end

    // Control registers and their write strobes.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            // NOTE: ctrl_q is a small flop array, not a RAM, so each entry is reset to its own value.
            for (int i = 0; i < NUM_RW; i++) ctrl_q[i] <= RW_RST[32*i +: 32];
            stb_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only; a later write in this block overrides the default.
            stb_q <= '0;
            for (int i = 0; i < NUM_RW; i++) begin
                if (wr_acc && (addr_w == 32'(i))) begin
                    ctrl_q[i] <= (ctrl_q[i] & ~lane_mask) | (wdat & lane_mask);
                    // The strobe fires even if the written bytes leave the data unchanged.
                    stb_q[i]  <= 1'b1;
                end
            end
        end
    end

    // IRQ pending, mask and registered output. A set pulse wins over a W1C
    // clear of the same bit in the same cycle.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pend_q <= '0;
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            pend_q <= (pend_q & ~clr) | irq_set_i;
            mask_q <= mask_d;
            irq_q  <= |(pend_q & mask_q);
        end
    end

    // Read FSM. The data is captured at the accept edge and copied into rdat
    // on entry to DONE, so rdat keeps its previous value until the read
    // completes. A reset drops any read in flight.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= S_IDLE;
            wait_cnt <= 2'd0;
            rd_buf   <= 32'h0000_0000;
            rdat_q   <= 32'h0000_0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rd_acc) begin
                        if (RD_LAT == 1) begin
                            rdat_q <= rd_mux;
                            state  <= S_DONE;
                        end else begin
                            rd_buf   <= rd_mux;
                            wait_cnt <= WAIT_INIT;
                            state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        rdat_q <= rd_buf;
                        state  <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ctrl_o = '0;
        for (int i = 0; i < NUM_RW; i++) ctrl_o[32*i +: 32] = ctrl_q[i];
    end

    assign rdat     = rdat_q;
    assign wr_stb_o = stb_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_soc_csr_bank.sv
// -----------------------------------------------------------------------------
// tb_soc_csr_bank
//   Self-checking bench for soc_csr_bank. The DUT is configured with
//   RD_LAT=3 and distinct reset values for the control registers.
//
//   The reference model keeps the register file as plain arrays. It applies
//   bus writes, IRQ set pulses and unmapped-access counting once per clock.
//   Reads are predicted from the model at the accept cycle.
//
//   Sequence: directed scenarios first, then random traffic, then a reset
//   asserted while a read is in flight.
// -----------------------------------------------------------------------------
module tb_soc_csr_bank;

    localparam int NUM_RW = 8;
    localparam int NUM_RO = 4;
    localparam int IRQ_W  = 8;
    localparam int ADDR_W = 11;
    localparam int RD_LAT = 3;
    localparam int P      = NUM_RW + NUM_RO;
`ifdef CSR_BANK_ERRCNT_EN
    localparam int MAP_TOP = P + 3;
`else
    localparam int MAP_TOP = P + 2;
`endif
    localparam logic [NUM_RW*32-1:0] RST_VALS = {
        32'h7777_0007, 32'h6666_0006, 32'h5555_0005, 32'h4444_0004,
        32'h3333_0003, 32'hDEAD_BEEF, 32'h0000_0000, 32'hA5A5_0001
    };

    logic                  clk = 1'b0;
    logic                  arst_n;
    logic                  vld;
    logic                  rdy;
    logic [3:0]            we;
    logic [ADDR_W-1:0]     addr;
    logic [31:0]           wdat;
    logic [31:0]           rdat;
    logic [NUM_RW*32-1:0]  ctrl_o;
    logic [NUM_RW-1:0]     wr_stb_o;
    logic [NUM_RO*32-1:0]  status_i;
    logic [IRQ_W-1:0]      irq_set_i;
    logic                  irq_o;

    soc_csr_bank #(
        .NUM_RW (NUM_RW),
        .NUM_RO (NUM_RO),
        .IRQ_W  (IRQ_W),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT),
        .RW_RST (RST_VALS)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .vld       (vld),
        .rdy       (rdy),
        .we        (we),
        .addr      (addr),
        .wdat      (wdat),
        .rdat      (rdat),
        .ctrl_o    (ctrl_o),
        .wr_stb_o  (wr_stb_o),
        .status_i  (status_i),
        .irq_set_i (irq_set_i),
        .irq_o     (irq_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [31:0]        m_ctrl [NUM_RW];
    logic [IRQ_W-1:0]   m_pend;
    logic [IRQ_W-1:0]   m_mask;
    logic [NUM_RW-1:0]  m_stb;
    logic               m_irq;
    int                 m_err;
    logic               rd_acc_now = 1'b0;   // high in the cycle a read is presented for acceptance
    logic               irq_rand   = 1'b0;
    logic               mon_en     = 1'b0;

    always @(posedge clk or negedge arst_n) begin : model
        int          ai;
        logic [31:0] merged;
        logic [31:0] clr_bits;
        if (!arst_n) begin
            for (int i = 0; i < NUM_RW; i++) m_ctrl[i] = RST_VALS[32*i +: 32];
            m_pend = '0;
            m_mask = '0;
            m_stb  = '0;
            m_irq  = 1'b0;
            m_err  = 0;
        end else begin
            m_irq    = (m_pend & m_mask) != '0;
            m_stb    = '0;
            clr_bits = 32'h0;
            ai       = int'(addr);
            if (vld && we != 4'b0000) begin
                if (ai < NUM_RW) begin
                    merged = m_ctrl[ai];
                    for (int k = 0; k < 4; k++) if (we[k]) merged[8*k +: 8] = wdat[8*k +: 8];
                    m_ctrl[ai] = merged;
                    m_stb[ai]  = 1'b1;
                end else if (ai == P) begin
                    for (int k = 0; k < 4; k++) if (we[k]) clr_bits[8*k +: 8] = wdat[8*k +: 8];
                end else if (ai == P + 1) begin
                    merged = 32'(m_mask);
                    for (int k = 0; k < 4; k++) if (we[k]) merged[8*k +: 8] = wdat[8*k +: 8];
                    m_mask = merged[IRQ_W-1:0];
                end
`ifdef CSR_BANK_ERRCNT_EN
                if (ai == P + 2) m_err = 0;
`endif
            end
`ifdef CSR_BANK_ERRCNT_EN
            if (((vld && we != 4'b0000) || rd_acc_now) && ai >= MAP_TOP && m_err < 65535)
                m_err = m_err + 1;
`endif
            m_pend = (m_pend & ~clr_bits[IRQ_W-1:0]) | irq_set_i;
        end
    end

    function automatic logic [31:0] ref_read(input int a);
        if (a < NUM_RW)         return m_ctrl[a];
        if (a < P)              return status_i[32*(a-NUM_RW) +: 32];
        if (a == P)             return 32'(m_pend);
        if (a == P + 1)         return 32'(m_mask);
`ifdef CSR_BANK_ERRCNT_EN
        if (a == P + 2)         return 32'(m_err);
`endif
        return 32'h0;
    endfunction

    // Continuous comparison of the outputs that change without a handshake.
    always @(negedge clk) begin
        if (arst_n && mon_en) begin
            for (int i = 0; i < NUM_RW; i++) check("ctrl_o", ctrl_o[32*i +: 32], m_ctrl[i]);
            check("wr_stb_o", 32'(wr_stb_o), 32'(m_stb));
            check("irq_o", 32'(irq_o), 32'(m_irq));
        end
    end

    // ---------------- stimulus helpers (call at posedge+1) ----------------
    function automatic logic [IRQ_W-1:0] rnd_irq();
        if (irq_rand && $urandom_range(0, 5) == 0) return IRQ_W'($urandom);
        return '0;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
        irq_set_i = rnd_irq();
    endtask

    task automatic do_write(input int a, input logic [3:0] w, input logic [31:0] d,
                            input logic [IRQ_W-1:0] irq);
        vld = 1'b1; we = w; addr = ADDR_W'(a); wdat = d; irq_set_i = irq;
        @(negedge clk);
        check("wr_rdy", 32'(rdy), 32'h1);
        @(posedge clk); #1;
        vld = 1'b0; we = 4'b0000; irq_set_i = rnd_irq();
    endtask

    task automatic do_read(input int a, output logic [31:0] got);
        logic [31:0] exp;
        vld = 1'b1; we = 4'b0000; addr = ADDR_W'(a); rd_acc_now = 1'b1;
        @(negedge clk);
        exp = ref_read(a);
        check("rd_rdy_accept", 32'(rdy), 32'h0);
        for (int k = 1; k <= RD_LAT; k++) begin
            tick();
            rd_acc_now = 1'b0;
            // The status inputs move after the accept edge; the read must return the sampled value.
            status_i = {NUM_RO{$urandom}};
            @(negedge clk);
            if (k < RD_LAT) begin
                check("rd_rdy_early", 32'(rdy), 32'h0);
            end else begin
                check("rd_rdy", 32'(rdy), 32'h1);
                check("rd_data", rdat, exp);
            end
        end
        tick();
        vld = 1'b0;
        @(negedge clk);
        check("rd_rdy_one_cycle", 32'(rdy), 32'h0);
        check("rd_data_hold", rdat, exp);
        got = rdat;
        @(posedge clk); #1;
        irq_set_i = rnd_irq();
    endtask

    function automatic int rnd_addr();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, (1 << ADDR_W) - 1));
        return int'($urandom_range(0, MAP_TOP + 1));
    endfunction

    // ---------------- main sequence ----------------
    initial begin : main
        logic [31:0] got;
        arst_n = 1'b0; vld = 1'b0; we = 4'b0000; addr = '0; wdat = '0;
        irq_set_i = '0; status_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdy", 32'(rdy), 32'h0);
        check("rst_rdat", rdat, 32'h0);
        check("rst_irq", 32'(irq_o), 32'h0);
        check("rst_ctrl0", ctrl_o[31:0], 32'hA5A5_0001);
        #2 arst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Reset value of reg0 read back with full latency.
        do_read(0, got);
        check("t1_reg0", got, 32'hA5A5_0001);

        // Byte-lane write to reg1 with its strobe in the following cycle.
        vld = 1'b1; we = 4'b0011; addr = ADDR_W'(1); wdat = 32'h1234_5678;
        @(negedge clk);
        check("t2_rdy_same_cycle", 32'(rdy), 32'h1);
        @(posedge clk); #1;
        vld = 1'b0; we = 4'b0000;
        @(negedge clk);
        check("t2_stb", 32'(wr_stb_o), 32'h0000_0002);
        check("t2_ctrl1", ctrl_o[63:32], 32'h0000_5678);
        @(posedge clk); #1;
        check("t2_stb_pulse", 32'(wr_stb_o), 32'h0);
        do_read(1, got);
        check("t2_reg1", got, 32'h0000_5678);

        // Status read with RD_LAT=3.
        status_i[31:0] = 32'hCAFE_F00D;
        do_read(NUM_RW, got);
        check("t3_status0", got, 32'hCAFE_F00D);

        // IRQ: unmask bit 0, pulse set, then W1C colliding with a set.
        do_write(P + 1, 4'b0001, 32'h0000_0001, '0);
        irq_set_i = 8'h01;
        @(posedge clk); #1;
        irq_set_i = '0;
        @(posedge clk); #1;
        check("t4_irq_o", 32'(irq_o), 32'h1);
        do_write(P, 4'b0001, 32'h0000_0001, 8'h01);
        do_read(P, got);
        check("t4_pend_kept", got, 32'h0000_0001);
        do_write(P, 4'b0001, 32'h0000_0001, '0);
        do_read(P, got);
        check("t4_pend_cleared", got, 32'h0);

`ifdef CSR_BANK_ERRCNT_EN
        do_write((1 << ADDR_W) - 1, 4'b1111, 32'hFFFF_FFFF, '0);
        do_read((1 << ADDR_W) - 1, got);
        check("t6_unmapped_rd", got, 32'h0);
        do_write((1 << ADDR_W) - 1, 4'b0001, 32'h0000_00FF, '0);
        do_read(P + 2, got);
        check("t6_errcnt3", got, 32'h0000_0003);
        do_write(P + 2, 4'b0001, 32'h0, '0);
        do_read(P + 2, got);
        check("t6_errcnt_clr", got, 32'h0);
`else
        do_write(P + 2, 4'b1111, 32'hFFFF_FFFF, '0);
        do_read(P + 2, got);
        check("t6_p2_unmapped", got, 32'h0);
`endif

        // Random traffic against the model.
        irq_rand = 1'b1;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0, 1: do_write(rnd_addr(), 4'($urandom_range(1, 15)), $urandom, rnd_irq());
                2:    do_read(rnd_addr(), got);
                default: begin
                    status_i = {NUM_RO{$urandom}};
                    tick();
                end
            endcase
        end
        irq_rand = 1'b0;
        irq_set_i = '0;
        @(posedge clk); #1;

        // Reset while a read is waiting: no rdy for the dropped read.
        vld = 1'b1; we = 4'b0000; addr = ADDR_W'(NUM_RW); rd_acc_now = 1'b1;
        @(posedge clk); #1;
        rd_acc_now = 1'b0;
        @(negedge clk);
        check("t5_wait_rdy", 32'(rdy), 32'h0);
        #2 arst_n = 1'b0; vld = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("t5_rst_rdy", 32'(rdy), 32'h0);
        end
        #2 arst_n = 1'b1;
        for (int k = 0; k < RD_LAT + 2; k++) begin
            @(negedge clk);
            check("t5_no_rdy", 32'(rdy), 32'h0);
            check("t5_rdat_rst", rdat, 32'h0);
            check("t5_irq_rst", 32'(irq_o), 32'h0);
        end
        @(posedge clk); #1;
        do_read(2, got);
        check("t5_reg2_rst", got, 32'hDEAD_BEEF);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
